seqdec_param: RTL
=================

Name: seqdec_param

Overview:
Parametrised, run-time programmable serial sequence detector. It is the successor to the fixed 8-bit hard-coded pattern detectors in the same codebase. One serial bit arrives per enabled clock. The block compares the last WIDTH bits against a loadable pattern, flags matches with a registered (Moore-style) one-cycle pulse, supports overlapping and non-overlapping modes, and keeps a saturating match count for the surrounding test/control logic.

Parameters:
WIDTH, 8, pattern length in bits; legal range 2..16
PATTERN, 8'b10010011, pattern register value after reset (WIDTH bits, MSB = oldest bit)
CNT_W, 8, width of the match counter

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
Inp  input  1  serial data bit, sampled when En=1
En  input  1  sample enable; Inp is consumed only on edges where En=1
Overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every enabled edge
Load  input  1  load Pat_in into the pattern register
Pat_in  input  WIDTH  new pattern, MSB = first bit in time
Clear_cnt  input  1  synchronous clear of Match_cnt
Out  output  1  match pulse, registered
Armed  output  1  history holds WIDTH valid bits since the last reset/load/non-overlap match
Match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset (async, any time): history=0, fill=0, pattern reg=PATTERN, Out=0, Armed=0, Match_cnt=0. Takes effect immediately, without waiting for Clk.
- Internal state:
  - hist[WIDTH-1:0]: shift register; the newest bit enters at the LSB.
  - fill: width clog2(WIDTH+1); saturates at WIDTH.
  - pat[WIDTH-1:0]: pattern register.
  - Armed = (fill == WIDTH), driven combinationally from the fill register.
- Edge priority: Load > En. Clear_cnt acts independently on Match_cnt.
- Load=1: pat<=Pat_in; hist<=0; fill<=0; Out<=0. Inp and En are ignored on that edge. Match_cnt is unchanged.
- Load=0, En=1:
  - hist_n = {hist[WIDTH-2:0], Inp}; fill_n = min(fill+1, WIDTH).
  - match = (fill_n == WIDTH) && (hist_n == pat).
  - hist<=hist_n; Out<=match.
  - If match and Overlap=0: fill<=0, so the next match needs WIDTH fresh bits.
  - Otherwise: fill<=fill_n.
- Load=0, En=0: hist and fill hold; Out<=0. Out is never high for more than one consecutive cycle per match.
- Latency: Out is high for exactly one cycle, beginning after the rising edge that samples the final pattern bit. This is the same Moore timing as the existing detectors.
- Partial matches are never reported before fill reaches WIDTH, including after reset or load. Example: pat=0 with fill<WIDTH gives no match.
- Match_cnt:
  - On an edge with match=1, increments by 1 and saturates at 2^CNT_W-1.
  - Clear_cnt=1 sets it to 0 and wins over a coincident match; that match is not counted, but Out still pulses.
- Overlap toggling mid-stream: it affects only the edge on which it is sampled. No other state is disturbed.
- No X propagation: Inp is ignored when En=0 or Load=1.

Test Plan:
1. Reset; Overlap=1, En=1; stream 1,0,0,1,0,0,1,1 -> Out=1 for exactly the one cycle after the 8th edge; Armed=1 from the 8th edge; Match_cnt=1; Out=0 on every other cycle.
2. Overlap=1, stream 1,0,0,1,0,0,1,1,0,0,1,0,0,1,1 (15 bits) -> two Out pulses 7 enabled edges apart, Match_cnt=2. Repeat with Overlap=0 -> one pulse, Match_cnt=1, Armed drops to 0 after the match edge.
3. Load=1 with Pat_in=8'b10100101 after 4 random bits, then stream 1,0,1,0,0,1,0,1 -> no pulse for the pre-load bits; Armed=0 after the load; one pulse after the 8th post-load bit; Match_cnt increments to 1.
4. Default pattern with En=0 bubbles (1–3 idle cycles) between every bit, Inp toggling randomly during bubbles -> exactly one Out pulse, one cycle long, directly after the last enabled edge; Match_cnt=1.
5. CNT_W=2, Overlap=0, five back-to-back default patterns -> 5 Out pulses, Match_cnt sticks at 3. Then Clear_cnt=1 on the same edge as a 6th match -> Out pulses and Match_cnt=0.
6. Assert Reset asynchronously (between edges) after 5 bits of 10010011 -> Out, Armed, Match_cnt=0 immediately. Release and send the remaining 0,1,1 -> no match, Armed=0.

Source files
------------

// File: rtl/seqdec_param_if.sv
// Bus bundle for the programmable serial sequence detector.
// Handshake: i_en is a valid qualifier with an implicit always-ready sink; a bit is consumed on every rising edge with i_en=1 and i_load=0, and o_out is a one-cycle registered pulse with no backpressure.
interface seqdec_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             i_inp;
    logic             i_en;
    logic             i_overlap;
    logic             i_load;
    logic [WIDTH-1:0] i_pat_in;
    logic             i_clear_cnt;
    logic             o_out;
    logic             o_armed;
    logic [CNT_W-1:0] o_match_cnt;

    modport master (
        output i_inp, i_en, i_overlap, i_load, i_pat_in, i_clear_cnt,
        input  o_out, o_armed, o_match_cnt
    );

    modport slave (
        input  i_inp, i_en, i_overlap, i_load, i_pat_in, i_clear_cnt,
        output o_out, o_armed, o_match_cnt
    );
endinterface

// File: rtl/seqdec_param.sv
// Run-time programmable serial sequence detector with overlap control,
// registered match pulse and saturating match counter.
module seqdec_param #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PATTERN = 8'b10010011,
    parameter int               CNT_W   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seqdec_param_if.slave bus
);
    localparam int               FILL_W   = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [WIDTH-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [WIDTH-1:0]  r_pat;
    logic              r_out;
    logic [CNT_W-1:0]  r_cnt;

    logic [WIDTH-1:0]  w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_match;

    // Candidate history/fill as they would be after consuming i_inp this edge.
    always_comb begin
        w_hist_n = {r_hist[WIDTH-2:0], bus.i_inp};
        w_fill_n = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
        w_match  = bus.i_en && !bus.i_load &&
                   (w_fill_n == FILL_MAX) && (w_hist_n == r_pat);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_out  <= 1'b0;
        end else if (bus.i_load) begin
            r_pat  <= bus.i_pat_in;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (bus.i_en) begin
            r_hist <= w_hist_n;
            r_out  <= w_match;
            // Non-overlapping mode restarts the fill so the next match needs WIDTH fresh bits.
            r_fill <= (w_match && !bus.i_overlap) ? '0 : w_fill_n;
        end else begin
            r_out  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (bus.i_clear_cnt) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.o_out       = r_out;
    assign bus.o_armed     = (r_fill == FILL_MAX);
    assign bus.o_match_cnt = r_cnt;
endmodule
